// File: rtl/cypher_emitter_pkg.sv
// Shared cypher definitions: digit geometry defaults and emitter state encodings.
// The detector imports the same package so both sides agree on widths.
package cypher_emitter_pkg;

  localparam int unsigned CYPHER_DIGIT_W  = 4;
  localparam int unsigned CYPHER_N_DIGITS = 4;

  // Width of the inter-digit gap counter; GAP is limited to 0..15.
  localparam int unsigned GAP_CNT_W = 4;

  typedef enum logic [2:0] {
    StIdle = 3'b100,
    StSend = 3'b001,
    StGap  = 3'b010,
    StDone = 3'b011
  } state_e;

endpackage

// File: rtl/gap_counter.sv
// Loadable down-counter timing the idle cycles between accepted digits.
module gap_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic         enable,
  input  logic [W-1:0] load_value,
  output logic         zero
);

  logic [W-1:0] count;

  // Load wins over counting; the count parks at zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/cypher_emitter.sv
// Emits a latched cypher one digit at a time, MSB-first, over a read/ready
// handshake, with optional idle gaps between digits and a done pulse at the end.
module cypher_emitter
  import cypher_emitter_pkg::*;
#(
  parameter int unsigned DIGIT_W  = CYPHER_DIGIT_W,
  parameter int unsigned N_DIGITS = CYPHER_N_DIGITS,
  parameter int unsigned GAP      = 0
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        abort,
  input  logic [DIGIT_W*N_DIGITS-1:0] cypher_in,
  input  logic                        ready,
  output logic [DIGIT_W-1:0]          digit_out,
  output logic                        read,
  output logic                        busy,
  output logic                        done
);

  localparam int unsigned CypherW = DIGIT_W * N_DIGITS;
  localparam int unsigned IdxW    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [IdxW-1:0]      LastIdx = IdxW'(N_DIGITS - 1);
  // The gap state lasts GAP cycles: count GAP-1 down to zero inclusive.
  localparam logic [GAP_CNT_W-1:0] GapLoad = GAP_CNT_W'((GAP > 0) ? GAP - 1 : 0);

  state_e              state;
  logic [IdxW-1:0]     idx;
  logic [CypherW-1:0]  cypher_q;
  logic                transfer;
  logic                gap_load;
  logic                gap_zero;

  // Digit 0 is the most significant digit of the cypher.
  function automatic logic [DIGIT_W-1:0] digit_at(input logic [CypherW-1:0] c,
                                                  input logic [IdxW-1:0]    i);
    return c[(N_DIGITS - 1 - 32'(i)) * DIGIT_W +: DIGIT_W];
  endfunction

  assign transfer = (state == StSend) && ready && !abort;
  assign gap_load = transfer && (idx != LastIdx) && (GAP > 0);

  gap_counter #(
    .W(GAP_CNT_W)
  ) u_gap_counter (
    .clock      (clock),
    .reset      (reset),
    .load       (gap_load),
    .enable     (state == StGap),
    .load_value (GapLoad),
    .zero       (gap_zero)
  );

  // Control FSM; every output is registered together with the state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= StIdle;
      idx       <= '0;
      cypher_q  <= '0;
      digit_out <= '0;
      read      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start && !abort) begin
            state     <= StSend;
            cypher_q  <= cypher_in;
            idx       <= '0;
            digit_out <= digit_at(cypher_in, '0);
            read      <= 1'b1;
            busy      <= 1'b1;
          end
        end
        StSend: begin
          if (abort) begin
            state     <= StIdle;
            digit_out <= '0;
            read      <= 1'b0;
            busy      <= 1'b0;
          end else if (ready) begin
            if (idx == LastIdx) begin
              state     <= StDone;
              digit_out <= '0;
              read      <= 1'b0;
              done      <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
              if (GAP > 0) begin
                state     <= StGap;
                digit_out <= '0;
                read      <= 1'b0;
              end else begin
                digit_out <= digit_at(cypher_q, idx + 1'b1);
              end
            end
          end
        end
        StGap: begin
          if (abort) begin
            state <= StIdle;
            busy  <= 1'b0;
          end else if (gap_zero) begin
            state     <= StSend;
            digit_out <= digit_at(cypher_q, idx);
            read      <= 1'b1;
          end
        end
        StDone: begin
          // Abort is deliberately ignored here so the done pulse always completes.
          state <= StIdle;
          busy  <= 1'b0;
        end
        default: begin
          state     <= StIdle;
          digit_out <= '0;
          read      <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cypher_emitter.sv
// Bench for cypher_emitter: one GAP=0 and one GAP=2 instance, a digit-queue
// scoreboard with a tiny detector model, and directed literal checks.
`timescale 1ns/1ps
module tb_cypher_emitter;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        start_a = 1'b0, abort_a = 1'b0, ready_a = 1'b1;
  logic [15:0] cyph_a = '0;
  logic [3:0]  dig_a;
  logic        read_a, busy_a, done_a;

  logic        start_b = 1'b0, abort_b = 1'b0, ready_b = 1'b1;
  logic [15:0] cyph_b = '0;
  logic [3:0]  dig_b;
  logic        read_b, busy_b, done_b;

  cypher_emitter #(.DIGIT_W(4), .N_DIGITS(4), .GAP(0)) dut_a (
    .clock(clock), .reset(reset), .start(start_a), .abort(abort_a), .cypher_in(cyph_a),
    .ready(ready_a), .digit_out(dig_a), .read(read_a), .busy(busy_a), .done(done_a)
  );

  cypher_emitter #(.DIGIT_W(4), .N_DIGITS(4), .GAP(2)) dut_b (
    .clock(clock), .reset(reset), .start(start_b), .abort(abort_b), .cypher_in(cyph_b),
    .ready(ready_b), .digit_out(dig_b), .read(read_b), .busy(busy_b), .done(done_b)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model state: digits still owed by each DUT, gap tracking, end-of-cypher flag.
  logic [3:0]  q_a[$];
  logic [3:0]  q_b[$];
  logic        pend_a = 1'b0, last_a = 1'b0, pend_b = 1'b0, last_b = 1'b0;
  int          gap_a = 0, gap_b = 0;
  logic [15:0] word_a = '0;  // detector model: shift register of accepted digits

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_a(input logic [15:0] w);
    for (int i = 0; i < 4; i++) q_a.push_back(w[15-4*i -: 4]);
  endtask

  task automatic push_b(input logic [15:0] w);
    for (int i = 0; i < 4; i++) q_b.push_back(w[15-4*i -: 4]);
  endtask

  task automatic wait_done(input bit sel_b, input int max_cyc, input string name);
    int k = 0;
    while (!(sel_b ? done_b : done_a) && k < max_cyc) begin
      tick();
      k++;
    end
    check(name, sel_b ? done_b : done_a, 1);
  endtask

  // Scoreboard: every negedge, compare both DUTs with the queued digit stream.
  always @(negedge clock) begin
    if (reset) begin
      pend_a = 1'b0; last_a = 1'b0; pend_b = 1'b0; last_b = 1'b0;
    end else begin
      check("a_done", done_a, last_a);
      last_a = 1'b0;
      if (read_a || done_a) check("a_busy", busy_a, 1);
      if (read_a) begin
        if (pend_a) begin check("a_gap", gap_a, 0); pend_a = 1'b0; end
        if (q_a.size() == 0) check("a_unexpected_read", read_a, 0);
        else begin
          check("a_digit", dig_a, q_a[0]);
          if (ready_a && !abort_a) begin
            word_a = {word_a[11:0], dig_a};
            void'(q_a.pop_front());
            if (q_a.size() == 0) last_a = 1'b1;
            else begin pend_a = 1'b1; gap_a = 0; end
          end
        end
      end else begin
        check("a_idle_digit", dig_a, 0);
        if (pend_a) gap_a++;
      end
      if (abort_a) pend_a = 1'b0;

      check("b_done", done_b, last_b);
      last_b = 1'b0;
      if (read_b || done_b) check("b_busy", busy_b, 1);
      if (read_b) begin
        if (pend_b) begin check("b_gap", gap_b, 2); pend_b = 1'b0; end
        if (q_b.size() == 0) check("b_unexpected_read", read_b, 0);
        else begin
          check("b_digit", dig_b, q_b[0]);
          if (ready_b && !abort_b) begin
            void'(q_b.pop_front());
            if (q_b.size() == 0) last_b = 1'b1;
            else begin pend_b = 1'b1; gap_b = 0; end
          end
        end
      end else begin
        check("b_idle_digit", dig_b, 0);
        if (pend_b) gap_b++;
      end
      if (abort_b) pend_b = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [9:0] rd_pat;
  logic [3:0] dg_b [4];

  initial begin
    rd_pat = 10'b1001001001;
    dg_b   = '{4'hA, 4'h5, 4'hC, 4'h3};

    // Reset state.
    repeat (2) tick();
    check("rst_read_a", read_a, 0);
    check("rst_busy_a", busy_a, 0);
    check("rst_done_a", done_a, 0);
    check("rst_digit_a", dig_a, 0);
    check("rst_busy_b", busy_b, 0);
    reset = 1'b0;
    tick();

    // Basic emission with one-edge latency.
    cyph_a = 16'h1234; push_a(16'h1234); word_a = '0;
    start_a = 1'b1; tick(); start_a = 1'b0;
    check("t1_lat_read", read_a, 1);
    check("t1_d0", dig_a, 4'h1);
    tick(); check("t1_d1", dig_a, 4'h2);
    tick(); check("t1_d2", dig_a, 4'h3);
    tick(); check("t1_d3", dig_a, 4'h4);
    tick(); check("t1_done", done_a, 1); check("t1_read_off", read_a, 0);
    tick(); check("t1_done_off", done_a, 0); check("t1_busy_off", busy_a, 0);
    check("t1_detect", word_a == 16'h1234, 1);

    // Backpressure on digit 2.
    push_a(16'h1234); word_a = '0;
    start_a = 1'b1; tick(); start_a = 1'b0;
    tick(); check("t2_d1", dig_a, 4'h2);
    ready_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2_hold", dig_a, 4'h2);
      check("t2_hold_read", read_a, 1);
    end
    ready_a = 1'b1;
    tick(); check("t2_d2", dig_a, 4'h3);
    tick(); check("t2_d3", dig_a, 4'h4);
    tick(); check("t2_done", done_a, 1);
    tick(); check("t2_busy_off", busy_a, 0);
    check("t2_detect", word_a, 16'h1234);

    // Start and abort together in idle: abort wins.
    cyph_a = 16'hFFFF; start_a = 1'b1; abort_a = 1'b1; tick();
    start_a = 1'b0; abort_a = 1'b0;
    check("t3_busy", busy_a, 0);
    check("t3_read", read_a, 0);

    // Abort while digit 3 is presented, then a fresh emission.
    cyph_a = 16'h1234; push_a(16'h1234);
    start_a = 1'b1; tick(); start_a = 1'b0;
    tick(); tick(); check("t4_d2", dig_a, 4'h3);
    abort_a = 1'b1; tick(); abort_a = 1'b0; q_a.delete();
    check("t4_read", read_a, 0);
    check("t4_busy", busy_a, 0);
    check("t4_nodone", done_a, 0);
    tick(); check("t4_nodone2", done_a, 0);
    cyph_a = 16'h9999; push_a(16'h9999); word_a = '0;
    start_a = 1'b1; tick(); start_a = 1'b0;
    check("t4_new_d0", dig_a, 4'h9);
    wait_done(1'b0, 20, "t4_done_timeout");
    check("t4_detect", word_a, 16'h9999);
    tick(); check("t4_busy_off", busy_a, 0);

    // Async reset mid-cycle during SEND.
    cyph_a = 16'h1234; push_a(16'h1234);
    start_a = 1'b1; tick(); start_a = 1'b0;
    tick(); check("t5_d1", dig_a, 4'h2);
    #2 reset = 1'b1; q_a.delete();
    #1;
    check("t5_rst_read", read_a, 0);
    check("t5_rst_busy", busy_a, 0);
    check("t5_rst_digit", dig_a, 0);
    tick(); tick(); reset = 1'b0;
    tick(); check("t5_stay_idle", busy_a, 0); check("t5_no_read", read_a, 0);

    // Start and cypher changes during an emission are ignored.
    cyph_a = 16'h1234; push_a(16'h1234); word_a = '0;
    start_a = 1'b1; tick();
    check("t5b_d0", dig_a, 4'h1);
    cyph_a = 16'hFFFF; tick(); tick(); start_a = 1'b0;
    wait_done(1'b0, 20, "t5b_done_timeout");
    check("t5b_latched", word_a, 16'h1234);
    tick(); check("t5b_busy_off", busy_a, 0);

    // End-to-end: a wrong code must not be accepted by the detector model.
    cyph_a = 16'h1244; push_a(16'h1244); word_a = '0;
    start_a = 1'b1; tick(); start_a = 1'b0;
    wait_done(1'b0, 20, "t6_done_timeout");
    check("t6_reject", word_a == 16'h1234, 0);
    check("t6_word", word_a, 16'h1244);
    tick();

    // GAP=2 instance: exact read pattern, no gap before done.
    cyph_b = 16'hA5C3; push_b(16'hA5C3);
    start_b = 1'b1; tick(); start_b = 1'b0;
    begin
      int j = 0;
      for (int i = 0; i < 10; i++) begin
        check("t7_read_pat", read_b, rd_pat[i]);
        if (rd_pat[i]) begin
          check("t7_digit", dig_b, dg_b[j]);
          j++;
        end
        tick();
      end
    end
    check("t7_done", done_b, 1);
    check("t7_done_read", read_b, 0);
    tick(); check("t7_busy_off", busy_b, 0);

    // Abort inside a gap, then a clean run.
    cyph_b = 16'h1234; push_b(16'h1234);
    start_b = 1'b1; tick(); start_b = 1'b0;
    tick(); check("t8_in_gap", read_b, 0);
    abort_b = 1'b1; tick(); abort_b = 1'b0; q_b.delete();
    check("t8_busy", busy_b, 0);
    tick(); check("t8_nodone", done_b, 0);
    cyph_b = 16'h9999; push_b(16'h9999);
    start_b = 1'b1; tick(); start_b = 1'b0;
    wait_done(1'b1, 30, "t8_done_timeout");
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cypher_emitter.md
CYPHER_EMITTER -- requirements
Module: cypher_emitter

Interface
REQ-001 The parameter list SHALL contain: DIGIT_W, 4, width of one cypher digit.
REQ-002 The parameter list SHALL contain: N_DIGITS, 4, digits per cypher.
REQ-003 The parameter list SHALL contain: GAP, 0, idle cycles inserted between accepted digits (0..15).
REQ-004 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-005 The ports SHALL be:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous active-high reset.
- start  input  1  request to emit the cypher, sampled only in IDLE.
- abort  input  1  synchronous abort of an emission.
- cypher_in  input  DIGIT_W*N_DIGITS  cypher value, latched on the accepted start.
- ready  input  1  downstream (detector) accepts the current digit.
- digit_out  output  DIGIT_W  current digit; 0 whenever read=0.
- read  output  1  digit_out valid (drives the detector's read input).
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the last digit is accepted.

Function
REQ-006 The states SHALL be IDLE, SEND, GAP and DONE, with a digit index idx of width clog2(N_DIGITS).
REQ-007 IDLE with start=1 and abort=0 SHALL latch cypher_in, clear idx and enter SEND on the next edge.
REQ-008 Digits SHALL be emitted MSB-first: idx 0 is cypher_in[top DIGIT_W bits].
REQ-009 In SEND, read=1 and digit_out = digit[idx].
REQ-010 A digit SHALL transfer only on a cycle with read=1 and ready=1.
REQ-011 While read=1 and ready=0, digit_out and idx SHALL hold stable; there is no timeout.
REQ-012 On a transfer with idx < N_DIGITS-1: idx increments; the next state is GAP if GAP>0, else SEND (back-to-back digits).
REQ-013 On a transfer with idx = N_DIGITS-1 the next state SHALL be DONE; GAP SHALL NOT be inserted after the last digit.
REQ-014 GAP SHALL hold read=0 for exactly GAP cycles, then enter SEND.
REQ-015 DONE SHALL assert done=1 for one cycle, then enter IDLE.
REQ-016 Latency: start sampled at edge k gives first read=1 after edge k+1; with GAP=0 and ready tied high, digits occupy cycles k+1..k+4 and done is high in cycle k+5.
REQ-017 start outside IDLE SHALL be ignored; the latched cypher SHALL NOT change during an emission.
REQ-018 abort=1 in SEND or GAP SHALL force IDLE on the next edge with no done pulse; abort in DONE still lets done complete.
REQ-019 start and abort together in IDLE: abort wins, and the block stays IDLE.
REQ-020 ready while read=0 SHALL be ignored.
REQ-021 All outputs SHALL be registered or decoded from registered state only; there is no combinational path from ready to read.

Reset
REQ-022 Asserting reset SHALL immediately, without waiting for a clock edge, force the state to IDLE and clear idx, the GAP counter, the latched cypher, digit_out, read, busy and done to 0.
REQ-023 Reset asserted mid-emission SHALL discard the emission; after release the block waits for a new start.

Structure
REQ-024 The state encodings (IDLE=3'b100, SEND, GAP, DONE) and the DIGIT_W / N_DIGITS defaults SHALL live in a shared cypher definitions include, also used by the detector.
REQ-025 The GAP down-counter SHALL be one sub-module, gap_counter, with load, enable and zero flag; everything else stays in cypher_emitter.

Verification
REQ-026 Basic emission: GAP=0, ready=1, cypher_in=16'h1234, start pulse -> digit_out 1,2,3,4 on 4 consecutive read cycles, done in the next cycle, busy low after it.
REQ-027 Backpressure: ready=0 for 3 cycles while digit 2 is presented -> digit_out=2 held for 4 read cycles, then 3 and 4 follow, done once.
REQ-028 Gaps: GAP=2, ready=1, cypher 16'hA5C3 -> A,5,C,3 each separated by exactly 2 read=0 cycles, no gap before done.
REQ-029 Abort: abort pulsed while digit 3 is presented -> IDLE next cycle, read=0, no done; a new start with 16'h9999 then emits 9,9,9,9 correctly.
REQ-030 Async reset: reset raised mid-cycle during SEND -> read, busy and digit_out go to 0 before the next edge; start during busy is ignored and the latched cypher is unchanged.
REQ-031 End-to-end: emitter connected to the cypher detector, code 16'h1234 -> the detector reaches acceptance; code 16'h1244 -> the detector does not.
